// File: rtl/bp_pkg.sv
// Shared types, defaults and the saturating-counter rule for the gshare predictor.
package bp_pkg;

  // Default configuration: 2-bit counters written as weakly not-taken at init.
  localparam int CTR_W_DEF    = 2;
  localparam int CTR_INIT_DEF = 1;

  // Widest counter sat_update can handle; per-instance counters are sliced from it.
  localparam int CTR_MAX_W = 8;

  typedef logic [CTR_W_DEF-1:0] ctr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Saturating up/down step of a ctr_w-bit counter carried in a CTR_MAX_W field.
  function automatic logic [CTR_MAX_W-1:0] sat_update(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int                   ctr_w
  );
    logic [CTR_MAX_W-1:0] ctr_max;
    ctr_max = CTR_MAX_W'((1 << ctr_w) - 1);
    if (taken) begin
      sat_update = (ctr == ctr_max) ? ctr : ctr + CTR_MAX_W'(1);
    end else begin
      sat_update = (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
    end
  endfunction

endpackage

// File: rtl/pht_table.sv
// Pattern history table: combinational read, one write port shared by the
// init sweep and commit-time training (the sweep wins).
module pht_table
  import bp_pkg::*;
#(
  parameter int IDX_W    = 10,
  parameter int CTR_W    = CTR_W_DEF,
  parameter int CTR_INIT = CTR_INIT_DEF
) (
  input  logic             clk,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_ptr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0]     pht [DEPTH];
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [CTR_W-1:0]     wr_data;
  logic [CTR_MAX_W-1:0] trained;

  // Prediction sees the stored value; a same-cycle write is not bypassed.
  assign rd_ctr  = pht[rd_idx];
  assign trained = sat_update(CTR_MAX_W'(pht[upd_idx]), upd_taken, CTR_W);

  // Select the write source: init sweep over training.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_en   = init_en | upd_en;
    wr_idx  = upd_idx;
    wr_data = CTR_W'(trained);
    if (init_en) begin
      wr_idx  = init_ptr;
      wr_data = CTR_W'(CTR_INIT);
    end
  end

  // Table storage write.
  // NOTE: the array has no reset; the init sweep defines its contents before use.
  always_ff @(posedge clk) begin
    if (wr_en) pht[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare branch predictor top: global history, init/run FSM and index hashing.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W    = 10,
  parameter int HIST_W   = 10,
  parameter int CTR_W    = CTR_W_DEF,
  parameter int CTR_INIT = CTR_INIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              ready,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              mispredict,
  input  logic              mis_is_branch,
  input  logic [HIST_W-1:0] mis_hist,
  input  logic              mis_taken
);

  state_t            state, state_next;
  logic [IDX_W-1:0]  init_ptr, init_ptr_next;
  logic [HIST_W-1:0] ghr, ghr_next;
  logic [CTR_W-1:0]  rd_ctr;
  logic              unused_pc_bits;

  // PC bits outside the index field do not participate in the hash.
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  assign ready      = (state == RUN);
  assign pred_idx   = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign pred_hist  = ghr;
  assign pred_taken = ready & pred_valid & rd_ctr[CTR_W-1];

  pht_table #(
    .IDX_W   (IDX_W),
    .CTR_W   (CTR_W),
    .CTR_INIT(CTR_INIT)
  ) u_pht (
    .clk      (clk),
    .init_en  (state == INIT),
    .init_ptr (init_ptr),
    .rd_idx   (pred_idx),
    .rd_ctr   (rd_ctr),
    .upd_en   (ready & upd_valid),
    .upd_idx  (upd_idx),
    .upd_taken(upd_taken)
  );

  // State, sweep pointer and history registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
      ghr      <= '0;
    end else begin
      state    <= state_next;
      init_ptr <= init_ptr_next;
      ghr      <= ghr_next;
    end
  end

  // Next-state: sweep in INIT; in RUN clear, then recovery, then speculative shift.
  always_comb begin
    state_next    = state;
    init_ptr_next = init_ptr;
    ghr_next      = ghr;
    case (state)
      INIT: begin
        init_ptr_next = init_ptr + IDX_W'(1);
        ghr_next      = '0;
        if (&init_ptr) state_next = RUN;
      end
      RUN: begin
        if (clear_req) begin
          state_next    = INIT;
          init_ptr_next = '0;
          ghr_next      = '0;
        end else if (mispredict && mis_is_branch) begin
          ghr_next = (mis_hist << 1) | HIST_W'(mis_taken);
        end else if (mispredict) begin
          ghr_next = mis_hist;
        end else if (pred_valid) begin
          ghr_next = (ghr << 1) | HIST_W'(pred_taken);
        end
      end
      default: state_next = INIT;
    endcase
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor (IDX_W=4, HIST_W=4, CTR_W=2).
module tb_gshare_predictor;

  localparam int IDX_W  = 4;
  localparam int HIST_W = 4;
  localparam int N      = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear_req = 1'b0;
  logic              ready;
  logic              pred_valid = 1'b0;
  logic [31:0]       pred_pc = '0;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic [HIST_W-1:0] pred_hist;
  logic              upd_valid = 1'b0;
  logic [IDX_W-1:0]  upd_idx = '0;
  logic              upd_taken = 1'b0;
  logic              mispredict = 1'b0;
  logic              mis_is_branch = 1'b0;
  logic [HIST_W-1:0] mis_hist = '0;
  logic              mis_taken = 1'b0;

  int errors = 0;
  int checks = 0;

  gshare_predictor #(
    .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(2), .CTR_INIT(1)
  ) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_idx(pred_idx), .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .mispredict(mispredict), .mis_is_branch(mis_is_branch),
    .mis_hist(mis_hist), .mis_taken(mis_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: init countdown, integer counters, history as an integer.
  int m_left  = N;
  bit m_ready = 1'b0;
  int m_ghr   = 0;
  int m_pht [N];

  function automatic int m_index(input logic [31:0] pc);
    return ((pc >> 2) ^ m_ghr) % N;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = N; m_ready = 1'b0; m_ghr = 0;
    end else if (!m_ready) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) m_pht[i] = 1;
      end
    end else if (clear_req) begin
      m_ready = 1'b0; m_left = N; m_ghr = 0;
    end else begin
      int  mi;
      bit  mt;
      mi = m_index(pred_pc);
      mt = pred_valid && (m_pht[mi] >= 2);
      if (upd_valid) begin
        if (upd_taken) m_pht[upd_idx] = (m_pht[upd_idx] == 3) ? 3 : m_pht[upd_idx] + 1;
        else           m_pht[upd_idx] = (m_pht[upd_idx] == 0) ? 0 : m_pht[upd_idx] - 1;
      end
      if (mispredict)
        m_ghr = mis_is_branch ? (((mis_hist << 1) | mis_taken) % N) : int'(mis_hist);
      else if (pred_valid)
        m_ghr = ((m_ghr << 1) | mt) % (1 << HIST_W);
    end
  end

  // Every-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    if (!reset) begin
      int  mi;
      bit  exp_t;
      mi    = m_index(pred_pc);
      exp_t = m_ready && pred_valid && (m_pht[mi] >= 2);
      check("model_ready", 32'(ready), 32'(m_ready));
      check("model_idx", 32'(pred_idx), 32'(mi));
      check("model_hist", 32'(pred_hist), 32'(m_ghr));
      check("model_taken", 32'(pred_taken), 32'(exp_t));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational lookup that does not reach a clock edge.
  task automatic peek(input logic [31:0] pc, input string name, input logic exp);
    pred_valid = 1'b1;
    pred_pc    = pc;
    #1;
    check(name, 32'(pred_taken), 32'(exp));
    pred_valid = 1'b0;
    #1;
  endtask

  task automatic train(input logic [IDX_W-1:0] idx, input logic t);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = t;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic expect_init_sweep(input string name);
    for (int i = 0; i < N; i++) begin
      check(name, 32'(ready), 32'd0);
      tick();
    end
    check(name, 32'(ready), 32'd1);
  endtask

  initial begin
    // Reset, then a reset pulse after seven sweep writes.
    tick(); tick();
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_hist", 32'(pred_hist), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_init_sweep("init_latency");

    // Fresh table predicts not-taken everywhere.
    for (int i = 0; i < N; i++) peek(32'(i * 4), "fresh_not_taken", 1'b0);

    // Saturating training at idx 5 (pc 0x14 with ghr=0).
    train(4'd5, 1'b1); peek(32'h14, "train_T1_10", 1'b1);
    train(4'd5, 1'b1); peek(32'h14, "train_T2_11", 1'b1);
    train(4'd5, 1'b1); peek(32'h14, "train_T3_sat", 1'b1);
    train(4'd5, 1'b0); peek(32'h14, "train_N1_10", 1'b1);
    train(4'd5, 1'b0); peek(32'h14, "train_N2_01", 1'b0);
    train(4'd5, 1'b0); peek(32'h14, "train_N3_00", 1'b0);
    train(4'd5, 1'b0); peek(32'h14, "train_N4_floor", 1'b0);
    train(4'd5, 1'b1); peek(32'h14, "train_up_01", 1'b0);
    train(4'd5, 1'b1); peek(32'h14, "train_up_10", 1'b1);

    // History T, N, T on consecutive branches.
    pred_valid = 1'b1; pred_pc = 32'h14; #1;
    check("hist_b1", 32'(pred_hist), 32'h0);
    check("taken_b1", 32'(pred_taken), 32'd1);
    check("idx_b1", 32'(pred_idx), 32'd5);
    tick();
    pred_pc = 32'h00; #1;
    check("hist_b2", 32'(pred_hist), 32'h1);
    check("taken_b2", 32'(pred_taken), 32'd0);
    check("idx_b2", 32'(pred_idx), 32'd1);
    tick();
    pred_pc = 32'h1C; #1;
    check("hist_b3", 32'(pred_hist), 32'h2);
    check("taken_b3", 32'(pred_taken), 32'd1);
    check("idx_b3", 32'(pred_idx), 32'd5);
    tick();
    pred_valid = 1'b0; #1;
    check("hist_after_TNT", 32'(pred_hist), 32'h5);

    // Branch mispredict recovery; concurrent prediction is dropped.
    mispredict = 1'b1; mis_is_branch = 1'b1; mis_hist = 4'b0011; mis_taken = 1'b0;
    pred_valid = 1'b1; pred_pc = 32'h14;
    tick();
    mispredict = 1'b0; pred_valid = 1'b0; #1;
    check("mis_branch_hist", 32'(pred_hist), 32'h6);

    // Non-branch flush restores the checkpoint verbatim.
    mispredict = 1'b1; mis_is_branch = 1'b0; mis_hist = 4'b0011; mis_taken = 1'b1;
    pred_valid = 1'b1; pred_pc = 32'h14;
    tick();
    mispredict = 1'b0; pred_valid = 1'b0; #1;
    check("mis_flush_hist", 32'(pred_hist), 32'h3);

    // Same-cycle train and predict at idx 8: old value seen, new value next cycle.
    pred_valid = 1'b1; pred_pc = 32'h2C;
    upd_valid = 1'b1; upd_idx = 4'd8; upd_taken = 1'b1; #1;
    check("rw_same_idx", 32'(pred_idx), 32'd8);
    check("rw_old_value", 32'(pred_taken), 32'd0);
    tick();
    upd_valid = 1'b0; pred_pc = 32'h38; #1;
    check("rw_hist", 32'(pred_hist), 32'h6);
    check("rw_next_idx", 32'(pred_idx), 32'd8);
    check("rw_new_value", 32'(pred_taken), 32'd1);
    pred_valid = 1'b0; #1;

    // Clear re-runs the sweep and restores every counter to weakly not-taken.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clear_hist", 32'(pred_hist), 32'd0);
    expect_init_sweep("clear_sweep");
    for (int i = 0; i < N; i++) peek(32'(i * 4), "clear_ctr_01", 1'b0);
    check("clear_hist_kept", 32'(pred_hist), 32'd0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised gshare conditional-branch predictor for the fetch stage: a pattern history table of saturating counters indexed by PC XOR global history.
- Predicts in the same cycle as fetch and updates the global history speculatively on every predicted branch.
- Returns a history checkpoint with each prediction and restores history from that checkpoint on a mispredict; the ROB trains the counters at commit.
- Replaces the fixed 10-bit history register plus prediction buffer pair. Adds configurable sizes, checkpointed recovery, and a sequenced table initialisation/clear.

Parameters:
IDX_W, 10, PHT index width; table holds 2**IDX_W counters
HIST_W, 10, global history length; must satisfy 1 <= HIST_W <= IDX_W
CTR_W, 2, counter width; counter MSB is the prediction
CTR_INIT, 1, counter value written at init/clear (weakly not-taken)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
clear_req  in  1  re-initialise table and history (pulse)
ready  out  1  high when the table is usable (RUN state)
pred_valid  in  1  a conditional branch is being fetched this cycle
pred_pc  in  32  PC of that branch
pred_taken  out  1  prediction, combinational
pred_idx  out  IDX_W  PHT index used; travels with the instruction to commit
pred_hist  out  HIST_W  history before this branch's speculative shift (checkpoint)
upd_valid  in  1  commit of a conditional branch
upd_idx  in  IDX_W  stored pred_idx of the committing branch
upd_taken  in  1  resolved outcome
mispredict  in  1  pipeline flush
mis_is_branch  in  1  flushing instruction is a conditional branch
mis_hist  in  HIST_W  checkpoint of the flushing instruction
mis_taken  in  1  actual outcome; used only if mis_is_branch

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- Reset values:
  - state = INIT, init_ptr = 0, ghr = 0, ready = 0.
  - pred_taken = 0. pred_hist = 0.
  - pred_idx follows the combinational index.
- Index: idx = pred_pc[IDX_W+1:2] XOR zero-extended ghr.
  - pred_idx = idx at all times.
  - pred_hist = ghr at all times.
- Prediction: pred_taken = ready & pred_valid & pht[idx][CTR_W-1]. Zero latency.
- FSM INIT:
  - Each cycle writes CTR_INIT to pht[init_ptr], then increments init_ptr.
  - After writing entry 2**IDX_W-1, moves to RUN on that edge.
  - ready = 0 throughout INIT.
  - pred_valid, upd_valid and mispredict are ignored; ghr is held at 0.
- FSM RUN: ready = 1. clear_req moves to INIT with init_ptr = 0 and ghr = 0. clear_req has priority over all other inputs.
- Reset mid-INIT: the sweep restarts at entry 0.
- Init latency: ready rises exactly 2**IDX_W cycles after the first clk edge following reset deassertion.
- History, RUN only, priority order:
  1. mispredict & mis_is_branch: ghr <= {mis_hist[HIST_W-2:0], mis_taken}. For HIST_W = 1: ghr <= mis_taken.
  2. mispredict & !mis_is_branch: ghr <= mis_hist.
  3. pred_valid: ghr <= {ghr[HIST_W-2:0], pred_taken}.
  4. otherwise ghr holds.
  - A pred_valid in the same cycle as mispredict is discarded and does not shift.
- Training, RUN only: upd_valid writes pht[upd_idx] at the edge.
  - Taken: saturating increment, capped at 2**CTR_W-1.
  - Not taken: saturating decrement, floored at 0.
  - Training happens regardless of mispredict in the same cycle.
- Read/write same index in the same cycle: the prediction sees the old value (no bypass). The new value is visible next cycle.
- The pht array is not itself reset. Contents are defined only by the INIT sweep; nothing may depend on pht contents before ready.

Decomposition:
- Package bp_pkg holds:
  - ctr_t (logic [CTR_W-1:0]) and the state enum {INIT, RUN};
  - function sat_update(ctr, taken);
  - the default CTR_INIT constant.
- One sub-module: pht_table. It holds the storage, one combinational read port, one write port, and the INIT sweep mux, with a write-port select of init versus train.
- The top level holds ghr, the FSM, and the index logic.

Test Plan:
- IDX_W=4, reset released: ready low for 16 cycles and high on the 17th. Every lookup then gives pred_taken=0. A reset pulse mid-INIT at init_ptr=7 restarts the 16-cycle sweep.
- Training idx 5 (IDX_W=4): two taken commits step the counter 01 -> 10 -> 11. A third taken stays 11, and pred_taken=1 at idx 5. Three not-taken commits step it to 00, and a fourth stays 00.
- HIST_W=4, counters preset taken/not-taken so outcomes are T, N, T on three pred_valid cycles: pred_hist reads 0000, 0001, 0010, then ghr = 0101.
- Mispredict with mis_hist=0011, mis_is_branch=1, mis_taken=0, with pred_valid asserted the same cycle: ghr = 0110 and the pred_valid shift is dropped. With mis_is_branch=0 instead: ghr = 0011.
- Same-cycle upd_valid and pred_valid at equal index, counter 01, taken: pred_taken=0 that cycle and 1 the next cycle at the same index.
- clear_req in RUN after training: ready low the next cycle for 16 cycles, ghr=0, and all counters read 01 afterwards.
